corr_frame_reader: RTL and testbench
====================================

# corr_frame_reader

Consumer-side readout for the RFI correlation power stream. Captures each accumulated frame of 2^CHANNEL_ADDR per-channel power words (din/din_valid) into a ping-pong BRAM. Hands completed frames to a register/host reader through an address/read-enable port with a ready/done handshake. Sits directly after the correlation output and in front of the software register interface.

## Interface
- DIN_WIDTH, 16, width of the incoming unsigned power word and of rd_data
- CHANNEL_ADDR, 9, log2 of channels per frame; frame length N = 2^CHANNEL_ADDR
- clk  in  1  system clock; everything is on its rising edge
- rst  in  1  synchronous, active-high reset
- din  in  DIN_WIDTH  correlation power word, channel order 0..N-1
- din_valid  in  1  din qualifier; gaps between valids are allowed
- warning  in  1  overflow warning from the correlation datapath, sampled with din_valid
- rd_addr  in  CHANNEL_ADDR  channel to read from the read bank
- rd_en  in  1  read strobe
- rd_done  in  1  one-cycle pulse; host has finished with the current frame
- rd_data  out  DIN_WIDTH  read result
- rd_valid  out  1  rd_data qualifier
- frame_ready  out  1  a complete frame is held in the read bank
- frame_warn  out  1  warning seen at any point during the held frame
- frame_cnt  out  32  frames handed to the reader since reset
- drop_cnt  out  32  completed frames discarded because the reader still held a frame

## Operation
- Two banks, each N words: write bank `wb` and read bank `rb = ~wb`. BRAM address is {bank, channel}.
- Write side:
  - wr_ch counter starts at 0 and increments on every din_valid.
  - Each din_valid writes din to {wb, wr_ch}.
  - A valid with wr_ch == N-1 is the frame end (`fend`); wr_ch wraps to 0.
- Sticky warn_acc: set by (din_valid & warning), cleared on fend. The fend cycle's own warning is included in that frame.
- Bank FSM, states EMPTY and READY. frame_ready = (state == READY).
  - EMPTY & fend: toggle wb, frame_cnt++, frame_warn <= warn_acc | warning, go to READY.
  - READY & fend & !rd_done: frame dropped, drop_cnt++, wb unchanged. The next frame overwrites the same bank.
  - READY & rd_done & !fend: go to EMPTY. frame_warn is retained until the next swap.
  - READY & rd_done & fend: the release takes effect first, then the swap happens as from EMPTY. frame_cnt++, state stays READY, no drop.
  - EMPTY & rd_done: ignored.
- Read side:
  - Every rd_en reads {rb, rd_addr}, whatever the FSM state.
  - Reads in EMPTY return the last handed-over or stale data. This is legal and not flagged.
  - rd_en in the same cycle as a swap reads the bank selected before the swap.
- Counters wrap modulo 2^32.
- Reset:
  - wr_ch, wb, state, warn_acc, frame_warn, frame_cnt, drop_cnt, rd_valid and rd_data all go to 0.
  - Memory contents are not cleared.
  - Reset mid-frame discards the partial frame. The first din_valid after rst deasserts is channel 0.

## Timing
- Write: din is in memory the cycle after din_valid.
- Swap: frame_ready, frame_cnt and frame_warn update the cycle after the fend valid. drop_cnt also updates the cycle after fend.
- Read: fixed 2-cycle latency (BRAM register plus output register). rd_en at cycle t gives rd_valid/rd_data at t+2. Fully pipelined, one read per cycle.
- Read-during-write: same address is impossible because the ports address different banks.
- rd_done acts on the cycle it is sampled. frame_ready falls the following cycle.

## Configuration
- CORR_READER_WARN_EN defined:
  - warning is captured as described.
  - frame_warn reports per-frame overflow.
- CORR_READER_WARN_EN undefined:
  - warning is ignored, warn_acc is not built, frame_warn is tied to 0.
  - All other behaviour is identical.

## Structure
- Package corr_reader_pkg holds:
  - bank-FSM state encoding (EMPTY=0, READY=1)
  - localparam RD_LATENCY = 2
  - the 32-bit counter width constant
- Sub-module sdp_bram:
  - simple dual-port, depth 2^(CHANNEL_ADDR+1), width DIN_WIDTH
  - registered read output, one write port and one read port, both on clk
- Top level holds the write counter, bank FSM, counters, warning logic and the read output register.

## Test plan
- Bench CHANNEL_ADDR=3 (N=8) unless stated.
- Basic handoff: after rst, stream din=10..17 with gaps. Response: frame_ready=1 one cycle after the 8th valid, frame_cnt=1. Reading addr 0..7 returns 10..17, each 2 cycles after its rd_en.
- Drop: two frames sent (10..17, then 20..27) without rd_done. Response: drop_cnt=1, frame_cnt=1, read data still 10..17. Then pulse rd_done and send 30..37. Response: frame_cnt=2, read data 30..37.
- Simultaneous: rd_done asserted on the same cycle as frame 2's last valid. Response: no drop, frame_cnt=2, frame_ready stays 1, reads return frame 2.
- Reset mid-frame: rst asserted after 5 valids, then 8 valids of 40..47. Response: after rst, frame_ready=0 and both counters=0. The first new frame reads 40..47 with no misalignment.
- Warning: warning=1 on the channel 3 valid of frame 1, frame 2 clean, rd_done between the frames.
  - With CORR_READER_WARN_EN: frame_warn=1 after frame 1, 0 after frame 2.
  - Without the macro: frame_warn=0 throughout.

Source files
------------

// File: rtl/corr_reader_pkg.sv
// Shared types and constants for the correlation frame reader.
package corr_reader_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    READY = 1'b1
  } bank_state_e;

  localparam int RD_LATENCY = 2;
  localparam int CNT_WIDTH  = 32;

endpackage

// File: rtl/corr_frame_reader_sdp_bram.sv
// Simple dual-port block RAM: one write port, one registered read port, single clock.
module sdp_bram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/corr_frame_reader.sv
// Ping-pong capture of correlation power frames with a host readout handshake.
// Define CORR_READER_WARN_EN to build per-frame overflow warning tracking.
module corr_frame_reader
  import corr_reader_pkg::*;
#(
  parameter int DIN_WIDTH    = 16,
  parameter int CHANNEL_ADDR = 9
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DIN_WIDTH-1:0]    i_din,
  input  logic                    i_din_valid,
  input  logic                    i_warning,
  input  logic [CHANNEL_ADDR-1:0] i_rd_addr,
  input  logic                    i_rd_en,
  input  logic                    i_rd_done,
  output logic [DIN_WIDTH-1:0]    o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_frame_ready,
  output logic                    o_frame_warn,
  output logic [CNT_WIDTH-1:0]    o_frame_cnt,
  output logic [CNT_WIDTH-1:0]    o_drop_cnt
);

  logic [CHANNEL_ADDR-1:0] r_wr_ch;
  logic                    r_wb;
  bank_state_e             r_state;
  bank_state_e             w_state_next;
  logic                    w_fend;
  logic                    w_swap;
  logic                    w_drop;
  logic [CNT_WIDTH-1:0]    r_frame_cnt;
  logic [CNT_WIDTH-1:0]    r_drop_cnt;
  logic [RD_LATENCY-1:0]   r_rd_vld_sr;
  logic [DIN_WIDTH-1:0]    r_rd_data;
  logic [DIN_WIDTH-1:0]    w_bram_q;

  assign w_fend = i_din_valid && (r_wr_ch == {CHANNEL_ADDR{1'b1}});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ch <= '0;
    end else if (i_din_valid) begin
      r_wr_ch <= r_wr_ch + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A release coinciding with a frame end frees the bank first, so the new frame is taken, not dropped.
  always_comb begin
    w_state_next = r_state;
    w_swap       = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_fend) begin
          w_swap       = 1'b1;
          w_state_next = READY;
        end
      end
      READY: begin
        if (i_rd_done && w_fend) begin
          w_swap = 1'b1;
        end else if (i_rd_done) begin
          w_state_next = EMPTY;
        end else if (w_fend) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb        <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_swap) begin
        r_wb        <= ~r_wb;
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

`ifdef CORR_READER_WARN_EN
  logic r_warn_acc;
  logic r_frame_warn;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_warn_acc   <= 1'b0;
      r_frame_warn <= 1'b0;
    end else begin
      if (w_fend) begin
        r_warn_acc <= 1'b0;
      end else if (i_din_valid && i_warning) begin
        r_warn_acc <= 1'b1;
      end
      if (w_swap) begin
        r_frame_warn <= r_warn_acc | i_warning;
      end
    end
  end

  assign o_frame_warn = r_frame_warn;
`else
  logic w_unused_warning;
  assign w_unused_warning = i_warning;
  assign o_frame_warn     = 1'b0;
`endif

  // Write and read ports always address opposite banks, so they never collide.
  sdp_bram #(
    .WIDTH  (DIN_WIDTH),
    .ADDR_W (CHANNEL_ADDR + 1)
  ) u_bram (
    .i_clk   (i_clk),
    .i_we    (i_din_valid && !i_rst),
    .i_waddr ({r_wb, r_wr_ch}),
    .i_wdata (i_din),
    .i_re    (i_rd_en),
    .i_raddr ({~r_wb, i_rd_addr}),
    .o_rdata (w_bram_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_vld_sr <= '0;
      r_rd_data   <= '0;
    end else begin
      r_rd_vld_sr <= {r_rd_vld_sr[RD_LATENCY-2:0], i_rd_en};
      if (r_rd_vld_sr[RD_LATENCY-2]) begin
        r_rd_data <= w_bram_q;
      end
    end
  end

  assign o_rd_data     = r_rd_data;
  assign o_rd_valid    = r_rd_vld_sr[RD_LATENCY-1];
  assign o_frame_ready = (r_state == READY);
  assign o_frame_cnt   = r_frame_cnt;
  assign o_drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_corr_frame_reader.sv
// Testbench for corr_frame_reader with N=8 channels; honours CORR_READER_WARN_EN like the design.
module tb_corr_frame_reader;

  localparam int DW = 16;
  localparam int CA = 3;
  localparam int N  = 1 << CA;

`ifdef CORR_READER_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dinValid = 1'b0;
  logic          warning = 1'b0;
  logic [CA-1:0] rdAddr = '0;
  logic          rdEn = 1'b0;
  logic          rdDone = 1'b0;
  logic [DW-1:0] rdData;
  logic          rdValid;
  logic          frameReady;
  logic          frameWarn;
  logic [31:0]   frameCnt;
  logic [31:0]   dropCnt;

  always #5 clk = ~clk;

  corr_frame_reader #(
    .DIN_WIDTH    (DW),
    .CHANNEL_ADDR (CA)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_din         (din),
    .i_din_valid   (dinValid),
    .i_warning     (warning),
    .i_rd_addr     (rdAddr),
    .i_rd_en       (rdEn),
    .i_rd_done     (rdDone),
    .o_rd_data     (rdData),
    .o_rd_valid    (rdValid),
    .o_frame_ready (frameReady),
    .o_frame_warn  (frameWarn),
    .o_frame_cnt   (frameCnt),
    .o_drop_cnt    (dropCnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frames as word lists; the reader sees whichever frame was last handed over.
  bit          mHeld;
  bit          mHeldKnown;
  int          mHeldFrame [N];
  int          mCur [$];
  bit          mWarnAcc;
  bit          mFrameWarn;
  logic [31:0] mFrameCnt;
  logic [31:0] mDropCnt;
  bit          mPendV;
  bit          mPendKnown;
  int          mPendD;
  bit          mExpV;
  bit          mExpKnown;
  int          mExpD;

  typedef struct {
    bit          rst;
    bit          vld;
    logic [DW-1:0] din;
    bit          ren;
    logic [CA-1:0] addr;
    bit          done;
    bit          expReady;
    logic [31:0] expCnt;
    bit          expRv;
    logic [DW-1:0] expData;
  } vec_t;

  vec_t vecs [$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic modelStep();
    if (rst) begin
      mHeld = 0; mHeldKnown = 0; mCur.delete(); mWarnAcc = 0; mFrameWarn = 0;
      mFrameCnt = 0; mDropCnt = 0; mPendV = 0; mPendKnown = 0; mPendD = 0;
      mExpV = 0; mExpKnown = 1; mExpD = 0;
    end else begin
      mExpV = mPendV;
      if (mPendV) begin
        mExpD = mPendD;
        mExpKnown = mPendKnown;
      end
      mPendV = rdEn;
      mPendKnown = mHeldKnown;
      mPendD = mHeldKnown ? mHeldFrame[rdAddr] : 0;
      if (rdDone) mHeld = 0;
      if (dinValid) begin
        mCur.push_back(int'(din));
        if (warning) mWarnAcc = 1;
        if (mCur.size() == N) begin
          if (!mHeld) begin
            mHeld = 1;
            mHeldKnown = 1;
            for (int k = 0; k < N; k++) mHeldFrame[k] = mCur[k];
            mFrameCnt = mFrameCnt + 1;
            mFrameWarn = mWarnAcc;
          end else begin
            mDropCnt = mDropCnt + 1;
          end
          mCur.delete();
          mWarnAcc = 0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("frame_ready", {31'd0, frameReady}, {31'd0, mHeld});
    checkVal("frame_cnt", frameCnt, mFrameCnt);
    checkVal("drop_cnt", dropCnt, mDropCnt);
    checkVal("frame_warn", {31'd0, frameWarn}, {31'd0, WARN_EN & mFrameWarn});
    checkVal("rd_valid", {31'd0, rdValid}, {31'd0, mExpV});
    if (mExpKnown) checkVal("rd_data", {16'd0, rdData}, 32'(mExpD));
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [DW-1:0] d, input bit w,
                               input bit re, input logic [CA-1:0] a, input bit dn);
    rst = r; dinValid = v; din = d; warning = w; rdEn = re; rdAddr = a; rdDone = dn;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic addVec(input bit r, input bit v, input int d, input bit re, input int a,
                        input bit dn, input bit er, input int ec, input bit erv, input int ed);
    vec_t t;
    t.rst = r; t.vld = v; t.din = DW'(d); t.ren = re; t.addr = CA'(a); t.done = dn;
    t.expReady = er; t.expCnt = 32'(ec); t.expRv = erv; t.expData = DW'(ed);
    vecs.push_back(t);
  endtask

  task automatic sendFrame(input int base, input int warnCh, input bit doneOnLast);
    for (int c = 0; c < N; c++) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(0, 0, '0, 0, 0, '0, 0);
      applyStimulus(0, 1, DW'(base + c), (c == warnCh), 0, '0, doneOnLast && (c == N - 1));
    end
  endtask

  task automatic readFrame(input int base);
    for (int i = 0; i < N + 2; i++) begin
      applyStimulus(0, 0, '0, 0, (i < N), CA'(i), 0);
      if (i >= 1 && i <= N) begin
        checkVal("seq_rd_valid", {31'd0, rdValid}, 32'd1);
        checkVal("seq_rd_data", {16'd0, rdData}, 32'(base + i - 1));
      end
    end
  endtask

  task automatic pulseDone();
    applyStimulus(0, 0, '0, 0, 0, '0, 1);
    checkVal("done_release", {31'd0, frameReady}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Basic handoff table: reset, frame 10..17 with gaps, then read back all channels.
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      if (i == 2 || i == 5) addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      addVec(0, 1, 10 + i, 0, 0, 0, (i == N - 1), (i == N - 1) ? 1 : 0, 0, 0);
    end
    for (int a = 0; a < N; a++) addVec(0, 0, 0, 1, a, 0, 1, 1, (a >= 1), 10 + a - 1);
    addVec(0, 0, 0, 0, 0, 0, 1, 1, 1, 17);
    addVec(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);

    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].din, 0, vecs[i].ren, vecs[i].addr, vecs[i].done);
      checkVal("tbl_ready", {31'd0, frameReady}, {31'd0, vecs[i].expReady});
      checkVal("tbl_cnt", frameCnt, vecs[i].expCnt);
      checkVal("tbl_rd_valid", {31'd0, rdValid}, {31'd0, vecs[i].expRv});
      if (vecs[i].expRv) checkVal("tbl_rd_data", {16'd0, rdData}, {16'd0, vecs[i].expData});
    end

    // Drop: second frame while the first is still held.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    sendFrame(10, -1, 0);
    sendFrame(20, -1, 0);
    checkVal("drop_dcnt", dropCnt, 32'd1);
    checkVal("drop_fcnt", frameCnt, 32'd1);
    readFrame(10);
    pulseDone();
    sendFrame(30, -1, 0);
    checkVal("drop_fcnt2", frameCnt, 32'd2);
    readFrame(30);

    // Release on the same cycle as the next frame end.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    sendFrame(50, -1, 0);
    sendFrame(60, -1, 1);
    checkVal("simul_dcnt", dropCnt, 32'd0);
    checkVal("simul_fcnt", frameCnt, 32'd2);
    checkVal("simul_ready", {31'd0, frameReady}, 32'd1);
    readFrame(60);

    // Reset in the middle of a frame.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    sendFrame(10, -1, 0);
    for (int c = 0; c < 5; c++) applyStimulus(0, 1, DW'(70 + c), 0, 0, '0, 0);
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    checkVal("rstmid_ready", {31'd0, frameReady}, 32'd0);
    checkVal("rstmid_fcnt", frameCnt, 32'd0);
    checkVal("rstmid_dcnt", dropCnt, 32'd0);
    sendFrame(40, -1, 0);
    checkVal("rstmid_fcnt1", frameCnt, 32'd1);
    readFrame(40);

    // Warning on channel 3 of frame 1, clean frame 2.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    sendFrame(80, 3, 0);
    checkVal("warn_f1", {31'd0, frameWarn}, {31'd0, WARN_EN});
    pulseDone();
    checkVal("warn_retained", {31'd0, frameWarn}, {31'd0, WARN_EN});
    sendFrame(90, -1, 0);
    checkVal("warn_f2", {31'd0, frameWarn}, 32'd0);

    // Randomised traffic against the model.
    applyStimulus(1, 0, '0, 0, 0, '0, 0);
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 6), DW'($urandom),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 1) == 1), CA'($urandom),
                    ($urandom_range(0, 14) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
